// File: rtl/bsg_hardfloat_fpu_arbiter.sv
// bsg_hardfloat_fpu_arbiter: round-robin sharing of one FPU among num_req_p requesters.
// Ports: clk_i/reset_i clock and synchronous reset; v_i/ready_o per-requester handshake
// carrying a_i/b_i/c_i/op_i/ipr_i/opr_i/rm_i; fpu_*_o operand bus to the FPU and
// fpu_data_i/fpu_eflags_i result from it; v_o/data_o/eflags_o/id_o show the response
// FIFO head, which yumi_i pops.
package bsg_hardfloat_pkg;
    localparam int dword_width_gp = 64;
    typedef enum logic [3:0] {
        e_op_add, e_op_sub, e_op_mul, e_op_fma, e_op_div,
        e_op_sqrt, e_op_min, e_op_max, e_op_cmp, e_op_cvt
    } bsg_fp_op_e;
    typedef enum logic [0:0] {e_pr_single, e_pr_double} bsg_fp_pr_e;
    typedef enum logic [2:0] {e_rm_rne, e_rm_rtz, e_rm_rdn, e_rm_rup, e_rm_rmm} bsg_fp_rm_e;
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } bsg_fp_eflags_s;
endpackage

module bsg_hardfloat_fpu_arbiter
    import bsg_hardfloat_pkg::*;
#(
    parameter int num_req_p = 4,
    parameter int latency_p = 2,
    parameter int fifo_els_p = latency_p + 1,
    localparam int id_width_lp = $clog2(num_req_p)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [num_req_p-1:0]                      v_i,
    input  logic [num_req_p-1:0][dword_width_gp-1:0]  a_i,
    input  logic [num_req_p-1:0][dword_width_gp-1:0]  b_i,
    input  logic [num_req_p-1:0][dword_width_gp-1:0]  c_i,
    input  bsg_fp_op_e [num_req_p-1:0]                op_i,
    input  bsg_fp_pr_e [num_req_p-1:0]                ipr_i,
    input  bsg_fp_pr_e [num_req_p-1:0]                opr_i,
    input  bsg_fp_rm_e [num_req_p-1:0]                rm_i,
    output logic [num_req_p-1:0]                      ready_o,
    output logic [dword_width_gp-1:0]                 fpu_a_o,
    output logic [dword_width_gp-1:0]                 fpu_b_o,
    output logic [dword_width_gp-1:0]                 fpu_c_o,
    output bsg_fp_op_e                                fpu_op_o,
    output bsg_fp_pr_e                                fpu_ipr_o,
    output bsg_fp_pr_e                                fpu_opr_o,
    output bsg_fp_rm_e                                fpu_rm_o,
    input  logic [dword_width_gp-1:0]                 fpu_data_i,
    input  bsg_fp_eflags_s                            fpu_eflags_i,
    output logic                                      v_o,
    output logic [dword_width_gp-1:0]                 data_o,
    output bsg_fp_eflags_s                            eflags_o,
    output logic [id_width_lp-1:0]                    id_o,
    input  logic                                      yumi_i
);
    localparam int cw_lp = $clog2(fifo_els_p + 1);
    localparam int pw_lp = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;

    logic [id_width_lp-1:0] ptr_r, w, idx;
    logic [cw_lp-1:0] credits_r, count_r;
    logic [pw_lp-1:0] rptr_r, wptr_r;
    logic found, gnt, wr;
    logic [latency_p:0] dv;
    logic [latency_p:0][id_width_lp-1:0] did;
    logic [dword_width_gp-1:0] mem_data [fifo_els_p];
    bsg_fp_eflags_s mem_flags [fifo_els_p];
    logic [id_width_lp-1:0] mem_id [fifo_els_p];

    function automatic logic [pw_lp-1:0] nxt(input logic [pw_lp-1:0] p);
        return (p == pw_lp'(fifo_els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    // Scanning from the farthest offset down lets the nearest valid requester after ptr_r win.
    always_comb begin
        found = 1'b0;
        w = '0;
        idx = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            idx = id_width_lp'((int'(ptr_r) + i) % num_req_p);
            if (v_i[idx]) begin
                found = 1'b1;
                w = idx;
            end
        end
    end

    assign gnt = found & ~reset_i & (credits_r != '0);
    assign ready_o = gnt ? num_req_p'(1) << w : '0;
    assign fpu_a_o = gnt ? a_i[w] : '0;
    assign fpu_b_o = gnt ? b_i[w] : '0;
    assign fpu_c_o = gnt ? c_i[w] : '0;
    assign fpu_op_o = gnt ? op_i[w] : bsg_fp_op_e'('0);
    assign fpu_ipr_o = gnt ? ipr_i[w] : bsg_fp_pr_e'('0);
    assign fpu_opr_o = gnt ? opr_i[w] : bsg_fp_pr_e'('0);
    assign fpu_rm_o = gnt ? rm_i[w] : bsg_fp_rm_e'('0);

    // Stage 0 is the grant itself, so latency_p=0 writes the FIFO in the issue cycle.
    assign dv[0] = gnt;
    assign did[0] = w;
    for (genvar s = 0; s < latency_p; s++) begin : g_dly
        always_ff @(posedge clk_i) begin
            dv[s+1] <= reset_i ? 1'b0 : dv[s];
            did[s+1] <= did[s];
        end
    end
    assign wr = dv[latency_p];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_r <= '0;
            credits_r <= cw_lp'(fifo_els_p);
            count_r <= '0;
            rptr_r <= '0;
            wptr_r <= '0;
        end else begin
            if (gnt) ptr_r <= (w == id_width_lp'(num_req_p - 1)) ? '0 : w + 1'b1;
            credits_r <= credits_r - cw_lp'(gnt) + cw_lp'(yumi_i);
            count_r <= count_r + cw_lp'(wr) - cw_lp'(yumi_i);
            if (wr) wptr_r <= nxt(wptr_r);
            if (yumi_i) rptr_r <= nxt(rptr_r);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) begin
            mem_data[wptr_r] <= fpu_data_i;
            mem_flags[wptr_r] <= fpu_eflags_i;
            mem_id[wptr_r] <= did[latency_p];
        end
    end

    assign v_o = count_r != '0;
    assign data_o = mem_data[rptr_r];
    assign eflags_o = mem_flags[rptr_r];
    assign id_o = mem_id[rptr_r];
endmodule
